// File: rtl/line_follow_pkg.sv
// Shared types for the line-following controller.
//   state_e   : controller sequence states
//   pattern_e : decoded sensor-bar pattern
//   drive_e   : motor drive modes
//   TURN_*    : turn command codes from the path planner
//   drive_dir : drive mode -> {m1_a, m1_b, m2_a, m2_b}
//   follow_drive : line-follow drive choice for a decoded pattern
package line_follow_pkg;

  typedef enum logic [2:0] {
    IDLE, FOLLOW, NODE, EXIT_FWD, TURN, SEEK, STOP
  } state_e;

  localparam logic [1:0] TURN_STRAIGHT = 2'd0;
  localparam logic [1:0] TURN_RIGHT    = 2'd1;
  localparam logic [1:0] TURN_UTURN    = 2'd2;
  localparam logic [1:0] TURN_LEFT     = 2'd3;

  typedef enum logic [2:0] {
    PAT_ALL_BLACK, PAT_ALL_WHITE, PAT_RIGHT, PAT_LEFT, PAT_STRAIGHT
  } pattern_e;

  typedef enum logic [2:0] {
    DRV_OFF, DRV_FWD, DRV_CORR_R, DRV_CORR_L, DRV_SPIN_R, DRV_SPIN_L
  } drive_e;

  function automatic logic [3:0] drive_dir(input drive_e mode);
    case (mode)
      DRV_FWD:                drive_dir = 4'b1010;
      DRV_CORR_R, DRV_SPIN_R: drive_dir = 4'b1001;
      DRV_CORR_L, DRV_SPIN_L: drive_dir = 4'b0110;
      default:                drive_dir = 4'b0000;
    endcase
  endfunction

  // All-white never reaches this: the caller holds the previous drive instead.
  function automatic drive_e follow_drive(input pattern_e pat);
    case (pat)
      PAT_RIGHT: follow_drive = DRV_CORR_R;
      PAT_LEFT:  follow_drive = DRV_CORR_L;
      default:   follow_drive = DRV_FWD;
    endcase
  endfunction

endpackage

// File: rtl/lfa_classifier.sv
// One line-sensor channel classifier with hysteresis.
//   clk, rst_n : clock, asynchronous active-low reset
//   sample     : raw ADC sample
//   black      : registered class (1 = black); samples between the
//                thresholds keep the previous class
module lfa_classifier
  import line_follow_pkg::*;
#(
  parameter int SENS_W = 12,
  parameter int HI_TH  = 1000,
  parameter int LO_TH  = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SENS_W-1:0] sample,
  output logic              black
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      black <= 1'b0;
    end else if (sample > SENS_W'(HI_TH)) begin
      black <= 1'b1;
    end else if (sample < SENS_W'(LO_TH)) begin
      black <= 1'b0;
    end
  end

endmodule

// File: rtl/line_follow_ctrl_n.sv
// Line-following controller: classifies NUM_SENS sensor channels, runs the
// follow / node / turn / seek sequence and drives the H-bridge.
//   clk_50M, rst_n     : clock, asynchronous active-low reset
//   start              : start level, acted on at its rising edge
//   sens               : packed samples, channel i at [i*SENS_W +: SENS_W]
//   turn_cmd/valid     : planner command (0 straight, 1 right, 2 U, 3 left)
//   turn_ready         : waiting at a node for a command
//   end_path           : stop request, overrides everything
//   m1_a..m2_b, dc1/2  : left/right direction bits and duty
//   node_flag          : at a node or turning
//   node_changed       : one-cycle pulse on node declaration
//   running            : not IDLE and not STOP
//   fault              : sticky lost-line / turn-timeout flag
// Optional macro SOFT_RAMP_EN: duty ramps +-1 every 2^10 cycles and ramps to
// zero before a direction change.
module line_follow_ctrl_n
  import line_follow_pkg::*;
#(
  parameter int SENS_W       = 12,
  parameter int NUM_SENS     = 3,
  parameter int HI_TH        = 1000,
  parameter int LO_TH        = 200,
  parameter int DUTY_W       = 5,
  parameter int DUTY_FWD     = 16,
  parameter int DUTY_CORR_HI = 20,
  parameter int DUTY_CORR_LO = 10,
  parameter int DUTY_TURN    = 18,
  parameter int NODE_DEB     = 4,
  parameter int TURN_MIN     = 2_500_000,
  parameter int TURN_TO      = 50_000_000,
  parameter int LOST_TO      = 25_000_000
) (
  input  logic                       clk_50M,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [NUM_SENS*SENS_W-1:0] sens,
  input  logic [1:0]                 turn_cmd,
  input  logic                       turn_valid,
  output logic                       turn_ready,
  input  logic                       end_path,
  output logic                       m1_a,
  output logic                       m1_b,
  output logic                       m2_a,
  output logic                       m2_b,
  output logic [DUTY_W-1:0]          dc1,
  output logic [DUTY_W-1:0]          dc2,
  output logic                       node_flag,
  output logic                       node_changed,
  output logic                       running,
  output logic                       fault
);

  localparam int CTR = NUM_SENS / 2;
  localparam int MW  = 4 + 2 * DUTY_W;
  localparam logic [31:0] NODE_LAST = 32'(NODE_DEB - 1);
  localparam logic [31:0] TURN_LAST = 32'(TURN_MIN - 1);
  localparam logic [31:0] SEEK_LAST = 32'(TURN_TO - 1);
  localparam logic [31:0] LOST_LAST = 32'(LOST_TO - 1);

  function automatic logic [MW-1:0] drive_word(input drive_e mode);
    logic [DUTY_W-1:0] d1;
    logic [DUTY_W-1:0] d2;
    case (mode)
      DRV_FWD:                begin d1 = DUTY_W'(DUTY_FWD);     d2 = DUTY_W'(DUTY_FWD);     end
      DRV_CORR_R:             begin d1 = DUTY_W'(DUTY_CORR_HI); d2 = DUTY_W'(DUTY_CORR_LO); end
      DRV_CORR_L:             begin d1 = DUTY_W'(DUTY_CORR_LO); d2 = DUTY_W'(DUTY_CORR_HI); end
      DRV_SPIN_R, DRV_SPIN_L: begin d1 = DUTY_W'(DUTY_TURN);    d2 = DUTY_W'(DUTY_TURN);    end
      default:                begin d1 = '0;                    d2 = '0;                    end
    endcase
    drive_word = {drive_dir(mode), d1, d2};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- stage p0: per-channel hysteresis classification ----
  logic [NUM_SENS-1:0] cls_p0;

  genvar g;
  generate
    for (g = 0; g < NUM_SENS; g++) begin : g_cls
      lfa_classifier #(
        .SENS_W (SENS_W),
        .HI_TH  (HI_TH),
        .LO_TH  (LO_TH)
      ) u_cls (
        .clk    (clk_50M),
        .rst_n  (rst_n),
        .sample (sens[g*SENS_W +: SENS_W]),
        .black  (cls_p0[g])
      );
    end
  endgenerate

  logic     right_any, left_any, seek_hit;
  pattern_e pat;

  assign right_any = |cls_p0[NUM_SENS-1:CTR+1];
  assign left_any  = |cls_p0[CTR-1:0];
  assign seek_hit  = cls_p0[CTR] & ~cls_p0[0] & ~cls_p0[NUM_SENS-1];

  always_comb begin
    pat = PAT_STRAIGHT;
    if (&cls_p0)                      pat = PAT_ALL_BLACK;
    else if (~|cls_p0)                pat = PAT_ALL_WHITE;
    else if (right_any && !left_any)  pat = PAT_RIGHT;
    else if (left_any && !right_any)  pat = PAT_LEFT;
  end

  // ---- stage p1: sequence control and registered drive targets ----
  state_e        state;
  logic          start_q, start_rise;
  logic [31:0]   node_cnt, lost_cnt, turn_cnt;
  logic          is_uturn, first_acq, hit_q;
  logic [MW-1:0] mot_p1;

  assign start_rise = start & ~start_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      node_cnt     <= '0;
      lost_cnt     <= '0;
      turn_cnt     <= '0;
      is_uturn     <= 1'b0;
      first_acq    <= 1'b0;
      hit_q        <= 1'b0;
      turn_ready   <= 1'b0;
      node_flag    <= 1'b0;
      node_changed <= 1'b0;
      running      <= 1'b0;
      fault        <= 1'b0;
      mot_p1       <= '0;
    end else begin
      start_q      <= start;
      node_changed <= 1'b0;
      if (end_path) begin
        state      <= STOP;
        turn_ready <= 1'b0;
        node_flag  <= 1'b0;
        running    <= 1'b0;
        mot_p1     <= drive_word(DRV_OFF);
      end else begin
        case (state)
          IDLE, STOP: begin
            if (start_rise) begin
              state    <= FOLLOW;
              running  <= 1'b1;
              fault    <= 1'b0;
              node_cnt <= '0;
              lost_cnt <= '0;
            end
          end
          FOLLOW: begin
            if (pat == PAT_ALL_WHITE) begin
              // Lost line: keep steering as before until the timeout.
              node_cnt <= '0;
              if (lost_cnt == LOST_LAST) begin
                state   <= STOP;
                fault   <= 1'b1;
                running <= 1'b0;
                mot_p1  <= drive_word(DRV_OFF);
              end else begin
                lost_cnt <= sat_inc(lost_cnt);
              end
            end else begin
              lost_cnt <= '0;
              if (pat == PAT_ALL_BLACK && node_cnt == NODE_LAST) begin
                state        <= NODE;
                node_changed <= 1'b1;
                node_flag    <= 1'b1;
                turn_ready   <= 1'b1;
                node_cnt     <= '0;
                mot_p1       <= drive_word(DRV_OFF);
              end else begin
                node_cnt <= (pat == PAT_ALL_BLACK) ? sat_inc(node_cnt) : '0;
                mot_p1   <= drive_word(follow_drive(pat));
              end
            end
          end
          NODE: begin
            if (turn_valid && turn_ready) begin
              turn_ready <= 1'b0;
              turn_cnt   <= '0;
              is_uturn   <= (turn_cmd == TURN_UTURN);
              case (turn_cmd)
                TURN_STRAIGHT: begin
                  state  <= EXIT_FWD;
                  mot_p1 <= drive_word(DRV_FWD);
                end
                TURN_LEFT: begin
                  state  <= TURN;
                  mot_p1 <= drive_word(DRV_SPIN_L);
                end
                default: begin
                  state  <= TURN;
                  mot_p1 <= drive_word(DRV_SPIN_R);
                end
              endcase
            end
          end
          EXIT_FWD: begin
            if (pat != PAT_ALL_BLACK) begin
              state     <= FOLLOW;
              node_flag <= 1'b0;
              node_cnt  <= '0;
              lost_cnt  <= '0;
            end
          end
          TURN: begin
            // Blind spin: sensors are ignored until the minimum time elapses.
            if (turn_cnt == TURN_LAST) begin
              state     <= SEEK;
              turn_cnt  <= '0;
              first_acq <= 1'b0;
              hit_q     <= 1'b0;
            end else begin
              turn_cnt <= sat_inc(turn_cnt);
            end
          end
          SEEK: begin
            hit_q <= seek_hit;
            // A U-turn passes over the line once; exit on the second rising
            // acquisition, any other turn exits on the first.
            if (seek_hit && (!is_uturn || (first_acq && !hit_q))) begin
              state     <= FOLLOW;
              node_flag <= 1'b0;
              node_cnt  <= '0;
              lost_cnt  <= '0;
              mot_p1    <= drive_word(DRV_FWD);
            end else if (turn_cnt == SEEK_LAST) begin
              state     <= STOP;
              fault     <= 1'b1;
              running   <= 1'b0;
              node_flag <= 1'b0;
              mot_p1    <= drive_word(DRV_OFF);
            end else begin
              turn_cnt <= sat_inc(turn_cnt);
              if (seek_hit && !hit_q) first_acq <= 1'b1;
            end
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            mot_p1  <= drive_word(DRV_OFF);
          end
        endcase
      end
    end
  end

  logic [3:0]        dir_p1;
  logic [DUTY_W-1:0] tgt1_p1, tgt2_p1;

  assign dir_p1  = mot_p1[MW-1 -: 4];
  assign tgt1_p1 = mot_p1[2*DUTY_W-1 -: DUTY_W];
  assign tgt2_p1 = mot_p1[DUTY_W-1:0];

`ifdef SOFT_RAMP_EN
  // ---- stage p2: duty slew toward the p1 targets ----
  function automatic logic [DUTY_W-1:0] step_to(input logic [DUTY_W-1:0] cur,
                                                input logic [DUTY_W-1:0] tgt);
    if (cur < tgt)      step_to = cur + 1'b1;
    else if (cur > tgt) step_to = cur - 1'b1;
    else                step_to = cur;
  endfunction

  logic [9:0]        ramp_div;
  logic [3:0]        dir_p2;
  logic [DUTY_W-1:0] dc1_p2, dc2_p2;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      ramp_div <= '0;
      dir_p2   <= '0;
      dc1_p2   <= '0;
      dc2_p2   <= '0;
    end else begin
      // Free-running prescaler: its wrap is the ramp tick.
      ramp_div <= ramp_div + 10'd1;
      if (end_path) begin
        dir_p2 <= '0;
        dc1_p2 <= '0;
        dc2_p2 <= '0;
      end else if (ramp_div == '1) begin
        if (dir_p2 != dir_p1) begin
          // Never reverse a loaded bridge: reach zero duty first.
          if (dc1_p2 == '0 && dc2_p2 == '0) begin
            dir_p2 <= dir_p1;
          end else begin
            dc1_p2 <= step_to(dc1_p2, '0);
            dc2_p2 <= step_to(dc2_p2, '0);
          end
        end else begin
          dc1_p2 <= step_to(dc1_p2, tgt1_p1);
          dc2_p2 <= step_to(dc2_p2, tgt2_p1);
        end
      end
    end
  end

  assign {m1_a, m1_b, m2_a, m2_b} = dir_p2;
  assign dc1 = dc1_p2;
  assign dc2 = dc2_p2;
`else
  assign {m1_a, m1_b, m2_a, m2_b} = dir_p1;
  assign dc1 = tgt1_p1;
  assign dc2 = tgt2_p1;
`endif

endmodule

// File: tb/tb_line_follow_ctrl_n.sv
// Directed bench for line_follow_ctrl_n: a pattern-decode vector table applied
// in FOLLOW, plus hand sequences for node debounce, turns, seek, lost-line,
// timeout, end_path and asynchronous reset.
module tb_line_follow_ctrl_n;

  localparam int TMIN = 8;
  localparam int TTO  = 40;
  localparam int LTO  = 12;

  localparam int D_FWD = 'b1010;
  localparam int D_CR  = 'b1001;
  localparam int D_CL  = 'b0110;
  localparam int D_OFF = 0;

  logic        clk_50M = 1'b0;
  logic        rst_n;
  logic        start;
  logic [35:0] sens;
  logic [1:0]  turn_cmd;
  logic        turn_valid;
  logic        turn_ready;
  logic        end_path;
  logic        m1_a, m1_b, m2_a, m2_b;
  logic [4:0]  dc1, dc2;
  logic        node_flag, node_changed, running, fault;
  logic [3:0]  dir_o;

  assign dir_o = {m1_a, m1_b, m2_a, m2_b};

  always #10 clk_50M = ~clk_50M;

  line_follow_ctrl_n #(
    .TURN_MIN (TMIN),
    .TURN_TO  (TTO),
    .LOST_TO  (LTO)
  ) dut (
    .clk_50M      (clk_50M),
    .rst_n        (rst_n),
    .start        (start),
    .sens         (sens),
    .turn_cmd     (turn_cmd),
    .turn_valid   (turn_valid),
    .turn_ready   (turn_ready),
    .end_path     (end_path),
    .m1_a         (m1_a),
    .m1_b         (m1_b),
    .m2_a         (m2_a),
    .m2_b         (m2_b),
    .dc1          (dc1),
    .dc2          (dc2),
    .node_flag    (node_flag),
    .node_changed (node_changed),
    .running      (running),
    .fault        (fault)
  );

  typedef struct {
    int s0;
    int s1;
    int s2;
    int dir;
    int d1;
    int d2;
  } vec_t;

  vec_t tbl [8];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic set_sens(input int a, input int b, input int c);
    sens = {c[11:0], b[11:0], a[11:0]};
  endtask

  task automatic goto_node();
    int n;
    set_sens(1500, 1500, 1500);
    n = 0;
    while (!turn_ready && n < 20) begin
      tick(1);
      n++;
    end
    chk("node_reached", 32'(turn_ready), 1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    // s0 (left), s1 (centre), s2 (right) -> dir, dc1, dc2
    tbl[0] = '{100,  100,  600,  D_CR,  20, 10}; // 600 keeps right black
    tbl[1] = '{1500, 100,  100,  D_CL,  10, 20};
    tbl[2] = '{1500, 1500, 100,  D_CL,  10, 20};
    tbl[3] = '{100,  1500, 1500, D_CR,  20, 10};
    tbl[4] = '{100,  100,  100,  D_CR,  20, 10}; // all white holds
    tbl[5] = '{1500, 100,  1500, D_FWD, 16, 16};
    tbl[6] = '{600,  1500, 100,  D_CL,  10, 20}; // 600 keeps left black
    tbl[7] = '{100,  1500, 600,  D_FWD, 16, 16}; // 600 keeps right white

    rst_n      = 1'b0;
    start      = 1'b0;
    end_path   = 1'b0;
    turn_cmd   = 2'd0;
    turn_valid = 1'b0;
    set_sens(100, 100, 100);
    #25;
    chk("reset_dir", 32'(dir_o), D_OFF);
    chk("reset_dc", 32'({dc1, dc2}), 0);
    chk("reset_flags", 32'({turn_ready, node_flag, node_changed, running, fault}), 0);

    @(posedge clk_50M);
    #1;
    rst_n = 1'b1;
    set_sens(100, 1500, 100);
    tick(2);
    chk("idle_off", 32'(dir_o), D_OFF);
    pulse_start();
    chk("start_running", 32'(running), 1);
    tick(1);
    chk("follow_dir", 32'(dir_o), D_FWD);
    chk("follow_dc1", 32'(dc1), 16);
    chk("follow_dc2", 32'(dc2), 16);

    // Two-cycle sample-to-motor latency
    set_sens(100, 100, 1500);
    tick(1);
    chk("lat_cycle1", 32'(dir_o), D_FWD);
    tick(1);
    chk("lat_cycle2", 32'(dir_o), D_CR);
    chk("corr_r_dc", 32'({dc1, dc2}), 32'({5'd20, 5'd10}));

    for (int i = 0; i < 8; i++) begin
      set_sens(tbl[i].s0, tbl[i].s1, tbl[i].s2);
      tick(2);
      chk($sformatf("vec%0d_dir", i), 32'(dir_o), tbl[i].dir);
      chk($sformatf("vec%0d_dc1", i), 32'(dc1), tbl[i].d1);
      chk($sformatf("vec%0d_dc2", i), 32'(dc2), tbl[i].d2);
    end

    // Three all-black cycles: one short of a node
    begin
      logic seen;
      seen = 1'b0;
      set_sens(1500, 1500, 1500);
      for (int i = 0; i < 8; i++) begin
        if (i == 3) set_sens(100, 1500, 100);
        tick(1);
        seen = seen | node_changed;
      end
      chk("deb3_no_node", 32'({seen, turn_ready, node_flag}), 0);
      chk("deb3_dir", 32'(dir_o), D_FWD);
    end

    // Four all-black cycles declare a node
    set_sens(1500, 1500, 1500);
    tick(4);
    chk("deb4_pre", 32'(node_changed), 0);
    tick(1);
    chk("node_pulse", 32'(node_changed), 1);
    chk("node_ready", 32'({turn_ready, node_flag}), 3);
    chk("node_off", 32'({dir_o, dc1, dc2}), 0);
    tick(1);
    chk("node_pulse_end", 32'(node_changed), 0);
    chk("node_ready_hold", 32'(turn_ready), 1);

    // Left turn: blind spin for TMIN cycles, then seek exits on centre line
    turn_cmd   = 2'd3;
    turn_valid = 1'b1;
    tick(1);
    chk("left_spin_dir", 32'(dir_o), D_CL);
    chk("left_spin_dc", 32'({dc1, dc2}), 32'({5'd18, 5'd18}));
    chk("left_ready_drop", 32'(turn_ready), 0);
    turn_valid = 1'b0;
    set_sens(100, 1500, 100);
    tick(TMIN);
    chk("left_turn_min", 32'({node_flag, dir_o}), 32'({1'b1, 4'b0110}));
    tick(1);
    chk("left_exit", 32'({node_flag, dir_o}), 32'({1'b0, 4'b1010}));

    // U-turn: first acquisition ignored, second exits
    goto_node();
    turn_cmd   = 2'd2;
    turn_valid = 1'b1;
    tick(1);
    chk("u_spin_dir", 32'(dir_o), D_CR);
    turn_valid = 1'b0;
    tick(TMIN + 2);
    set_sens(100, 1500, 100);
    tick(3);
    chk("u_first_ignored", 32'({node_flag, dir_o}), 32'({1'b1, 4'b1001}));
    set_sens(100, 100, 100);
    tick(3);
    set_sens(100, 1500, 100);
    tick(3);
    chk("u_second_exit", 32'({node_flag, dir_o}), 32'({1'b0, 4'b1010}));

    // Lost line: LTO all-white cycles
    set_sens(100, 100, 100);
    tick(LTO);
    chk("lost_pre", 32'({fault, running, dir_o}), 32'({1'b0, 1'b1, 4'b1010}));
    tick(1);
    chk("lost_stop", 32'({fault, running, dir_o}), 32'({1'b1, 1'b0, 4'b0000}));
    set_sens(100, 1500, 100);
    pulse_start();
    chk("restart_clear", 32'({fault, running}), 32'({1'b0, 1'b1}));
    tick(2);

    // Seek timeout
    goto_node();
    turn_cmd   = 2'd1;
    turn_valid = 1'b1;
    tick(1);
    chk("r_spin_dir", 32'(dir_o), D_CR);
    turn_valid = 1'b0;
    tick(TMIN + TTO - 1);
    chk("seek_to_pre", 32'({fault, running}), 32'({1'b0, 1'b1}));
    tick(1);
    chk("seek_to_stop", 32'({fault, running, dir_o}), 32'({1'b1, 1'b0, 4'b0000}));
    set_sens(100, 1500, 100);
    pulse_start();
    tick(2);

    // end_path mid-seek
    goto_node();
    turn_cmd   = 2'd1;
    turn_valid = 1'b1;
    tick(1);
    turn_valid = 1'b0;
    tick(TMIN + 2);
    chk("seek_spin", 32'(dir_o), D_CR);
    end_path = 1'b1;
    tick(1);
    chk("endp_off", 32'({dir_o, dc1, dc2}), 0);
    chk("endp_flags", 32'({running, node_flag}), 0);
    start = 1'b1;
    tick(1);
    chk("endp_blocks_start", 32'(running), 0);
    start    = 1'b0;
    end_path = 1'b0;
    tick(1);
    set_sens(100, 1500, 100);
    pulse_start();
    chk("endp_restart", 32'(running), 1);
    tick(2);

    // Asynchronous reset mid-turn
    goto_node();
    turn_cmd   = 2'd3;
    turn_valid = 1'b1;
    tick(1);
    turn_valid = 1'b0;
    tick(2);
    chk("turn_before_rst", 32'({running, dir_o}), 32'({1'b1, 4'b0110}));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_motor", 32'({dir_o, dc1, dc2}), 0);
    chk("async_rst_flags", 32'({turn_ready, node_flag, running, fault}), 0);
    @(posedge clk_50M);
    #1;
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_idle", 32'({running, dir_o}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_follow_ctrl_n.md
Name: line_follow_ctrl_n

Overview:
Parametrised successor line-following controller for the Astrotinker bot. It takes NUM_SENS line-sensor ADC channels and classifies each with hysteresis. It runs line-follow, node-detect and turn-execute sequences, and drives the H-bridge direction bits and PWM duty targets. It sits between the ADC sampler and the PWM generator, and takes turn commands from the path planner through a valid/ready handshake.

Parameters:
- SENS_W, 12: ADC sample width.
- NUM_SENS, 3: sensor count. Must be odd and ≥3. Centre index is NUM_SENS/2; index 0 is leftmost.
- HI_TH, 1000: a sample strictly above this classifies as black.
- LO_TH, 200: a sample strictly below this classifies as white. Anything between keeps the previous class.
- DUTY_W, 5: duty output width.
- DUTY_FWD, 16: straight-drive duty, both wheels.
- DUTY_CORR_HI / DUTY_CORR_LO, 20 / 10: correction duties for the outer and inner wheel.
- DUTY_TURN, 18: spin duty.
- NODE_DEB, 4: consecutive all-black cycles needed to declare a node.
- TURN_MIN, 2_500_000: blind-turn cycles before line seek begins.
- TURN_TO, 50_000_000: seek timeout in cycles.
- LOST_TO, 25_000_000: all-white cycles tolerated before a fault.

Ports:
- clk_50M, in, 1: system clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: start level. Sampled on its rising edge.
- sens, in, NUM_SENS*SENS_W: packed samples. Channel i occupies [i*SENS_W +: SENS_W].
- turn_cmd, in, 2: 0 = straight, 1 = right, 2 = U-turn, 3 = left.
- turn_valid, in, 1: turn_cmd is valid.
- turn_ready, out, 1: controller is waiting at a node for a command.
- end_path, in, 1: stop request.
- m1_a, m1_b, m2_a, m2_b, out, 1 each: left/right motor direction bits.
- dc1, dc2, out, DUTY_W each: left/right duty.
- node_flag, out, 1: high while the bot is at a node or turning.
- node_changed, out, 1: one-cycle pulse when a node is declared.
- running, out, 1: high in any state other than IDLE and STOP.
- fault, out, 1: sticky. Set on lost line or turn timeout.

Behaviour:
- Reset values:
  - All outputs 0 and direction bits 00.
  - State IDLE, counters 0, sensor classes white.
- Latency:
  - Classes are registered one cycle after the sample.
  - Motor outputs are registered one cycle after the class, so sample-to-motor latency is 2 cycles.
- Pattern decode, in priority order:
  1. ALL_BLACK.
  2. ALL_WHITE.
  3. RIGHT: a black channel exists right of centre and none left of it.
  4. LEFT: mirror of RIGHT.
  5. STRAIGHT: all other cases.
- Drive modes:
  - FWD: 10/10, DUTY_FWD on both wheels.
  - CORR_R: 10/01, dc1 = DUTY_CORR_HI, dc2 = DUTY_CORR_LO.
  - CORR_L: 01/10, dc1 = DUTY_CORR_LO, dc2 = DUTY_CORR_HI.
  - SPIN_R: 10/01, DUTY_TURN on both.
  - SPIN_L: 01/10, DUTY_TURN on both.
  - OFF: 00/00, duty 0.
- IDLE: drive OFF. Rising edge of start with end_path low → FOLLOW.
- FOLLOW:
  - Drives FWD, CORR_R or CORR_L from the decoded pattern.
  - ALL_WHITE holds the last drive mode and increments the lost counter. Reaching LOST_TO → STOP with fault set.
  - Any other pattern clears the lost counter.
  - ALL_BLACK for NODE_DEB consecutive cycles → NODE. The same cycle pulses node_changed and sets node_flag.
- NODE:
  - Drive OFF; turn_ready = 1.
  - A handshake completes in any cycle where turn_valid and turn_ready are both high. A turn_valid already high on NODE entry is accepted in the first NODE cycle.
  - On accept:
    - cmd 0 → EXIT_FWD: drive FWD until the pattern is not ALL_BLACK, then FOLLOW with node_flag cleared.
    - cmd 1 or 2 → TURN with SPIN_R.
    - cmd 3 → TURN with SPIN_L.
- TURN: drive the spin for exactly TURN_MIN cycles regardless of sensors, then → SEEK.
- SEEK:
  - Keep the spin.
  - Exit to FOLLOW when the centre channel is black and both outermost channels are white. node_flag clears on that transition.
  - For U-turn, the first qualifying acquisition is ignored and the second one exits.
  - TURN_TO cycles in SEEK → STOP with fault.
- STOP:
  - Drive OFF; running = 0.
  - Rising edge of start with end_path low clears fault → FOLLOW.
- end_path high overrides everything: → STOP from any state on the next edge.
- Reset mid-turn returns immediately to IDLE with motors OFF.
- All counters saturate and never wrap.

Optional Feature:
- SOFT_RAMP_EN defined: dc1 and dc2 step ±1 toward their target every 2^10 cycles. A direction-bit change first ramps the duty to 0, then switches direction and ramps up. OFF caused by end_path or reset bypasses the ramp and is immediate.
- SOFT_RAMP_EN undefined: duty takes the target directly with the 2-cycle latency.

Decomposition:
- Package line_follow_pkg holds:
  - state enum (IDLE, FOLLOW, NODE, EXIT_FWD, TURN, SEEK, STOP)
  - turn code constants
  - pattern enum
  - drive-mode enum
- Sub-module lfa_classifier: one instance per channel via generate. Performs the hysteresis HI_TH/LO_TH compare and registers the one-bit black output.

Test Plan:
- Centre channel = 1500, others = 100, start pulse → FOLLOW; outputs 10/10 and dc 16/16 on cycle 2 after the sample.
- Right channel = 1500, left = 100 → outputs 10/01 with dc 20/10. Right channel then set to 600 (between thresholds) → class stays black and the correction holds.
- All channels 1500 for 3 cycles then 100 → no node. All channels 1500 for 4 cycles → node_changed is a one-cycle pulse, turn_ready = 1.
- At the node, turn_cmd = 3 with valid: SPIN_L for TURN_MIN cycles, then centre black with outer channels white → FOLLOW and node_flag = 0. Repeat with turn_cmd = 2: the first acquisition is ignored.
- All channels white for LOST_TO cycles → STOP and fault = 1. A start rising edge then clears fault.
- end_path asserted mid-SEEK → outputs OFF on the next edge. rst_n asserted mid-TURN → all outputs 0 asynchronously.
